// File: rtl/seg_display_ctrl_if.sv
// Bus between the display datapath and the 8-digit scan controller: the digit
// word, dot/brightness controls and the multiplexed segment/select pins.
interface seg_display_ctrl_if;
    logic        en_in;
    logic [31:0] num_in;
    logic [7:0]  dp_in;
    logic [2:0]  bright_in;
    logic [7:0]  seg_out;
    logic [7:0]  sel_out;
    logic        frame_out;

    modport master (
        output en_in, num_in, dp_in, bright_in,
        input  seg_out, sel_out, frame_out
    );

    modport slave (
        input  en_in, num_in, dp_in, bright_in,
        output seg_out, sel_out, frame_out
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// 8-digit common-anode seven-segment scan controller with per-frame snapshot,
// decimal points, blank-code suppression and 8-level brightness PWM.
module seg_display_ctrl #(
    parameter int unsigned FREQUENCY_IN = 50_000_000,
    parameter int unsigned SCAN_HZ      = 8_000,
    parameter bit          BLANK_EN     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg_display_ctrl_if.slave  bus
);
    localparam int unsigned SLOT_CNT = FREQUENCY_IN / SCAN_HZ;
    localparam int unsigned SUB_CNT  = SLOT_CNT / 8;
    localparam int unsigned CNT_W    = $clog2(SUB_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SUB_CNT - 1);

    typedef enum logic {
        S_OFF,
        S_SCAN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sub_q, sub_d;
    logic [2:0]       digit_q, digit_d;
    logic [31:0]      num_sh_q, num_sh_d;
    logic [7:0]       dp_sh_q, dp_sh_d;
    logic [2:0]       bright_sh_q, bright_sh_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       sel_q, sel_d;
    logic             frame_q, frame_d;

    logic             cnt_wrap, sub_wrap, frame_wrap, snap, lit;
    logic [3:0]       nib;
    logic [6:0]       glyph;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
            4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
            4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
            4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;
            default: g = BLANK_EN ? 7'h7F : 7'h0E;
        endcase
        return g;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sub_d       = sub_q;
        digit_d     = digit_q;
        num_sh_d    = num_sh_q;
        dp_sh_d     = dp_sh_q;
        bright_sh_d = bright_sh_q;
        snap        = 1'b0;

        cnt_wrap   = (cnt_q == CNT_MAX);
        sub_wrap   = cnt_wrap && (sub_q == 3'd7);
        frame_wrap = sub_wrap && (digit_q == 3'd7);

        case (state_q)
            S_OFF: begin
                cnt_d   = '0;
                sub_d   = '0;
                digit_d = '0;
                if (bus.en_in) begin
                    state_d = S_SCAN;
                    snap    = 1'b1;
                end
            end
            default: begin
                if (!bus.en_in) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    sub_d   = '0;
                    digit_d = '0;
                end else begin
                    cnt_d   = cnt_wrap ? '0 : cnt_q + 1'b1;
                    sub_d   = cnt_wrap ? sub_q + 3'd1 : sub_q;
                    digit_d = sub_wrap ? digit_q + 3'd1 : digit_q;
                    snap    = frame_wrap;
                end
            end
        endcase

        if (snap) begin
            num_sh_d    = bus.num_in;
            dp_sh_d     = bus.dp_in;
            bright_sh_d = bus.bright_in;
        end

        // en_in low darkens the very next output so a drop never leaves a digit lit.
        lit   = (state_q == S_SCAN) && bus.en_in && (sub_q <= bright_sh_q);
        nib   = 4'(num_sh_q >> {~digit_q, 2'b00});
        glyph = decode(nib);

        seg_d   = lit ? {~dp_sh_q[digit_q], glyph} : 8'hFF;
        sel_d   = lit ? ~(8'd1 << digit_q) : 8'hFF;
        frame_d = (state_q == S_SCAN) && bus.en_in &&
                  (digit_q == 3'd0) && (sub_q == 3'd0) && (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            sub_q       <= '0;
            digit_q     <= '0;
            num_sh_q    <= '0;
            dp_sh_q     <= '0;
            bright_sh_q <= '0;
            seg_q       <= '1;
            sel_q       <= '1;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            digit_q     <= digit_d;
            num_sh_q    <= num_sh_d;
            dp_sh_q     <= dp_sh_d;
            bright_sh_q <= bright_sh_d;
            seg_q       <= seg_d;
            sel_q       <= sel_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.seg_out   = seg_q;
    assign bus.sel_out   = sel_q;
    assign bus.frame_out = frame_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with a cycle-level frame-position model
// feeding an expected-output queue, plus spot checks at scan boundaries.
module tb_seg_display_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    seg_display_ctrl_if bus();

    seg_display_ctrl #(
        .FREQUENCY_IN(640),
        .SCAN_HZ(8),
        .BLANK_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef logic [16:0] obs_t;   // {frame, sel, seg}

    int errors = 0;
    int checks = 0;

    logic [7:0] dec_tab [16];
    obs_t       exp_q [$];

    bit          m_on;
    int          m_t;
    logic [31:0] m_num;
    logic [7:0]  m_dp;
    logic [2:0]  m_b;

    function automatic obs_t observed();
        return {bus.frame_out, bus.sel_out, bus.seg_out};
    endfunction

    task automatic chk(input string tag, input obs_t obs, input obs_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Frame position t in 0..639: slot = t/80, lit while t%80 < (b+1)*10.
    function automatic obs_t model_out();
        int d, p;
        logic [3:0] nib;
        logic [7:0] seg;
        d = m_t / 80;
        p = m_t % 80;
        if (!m_on || !bus.en_in || p >= (int'(m_b) + 1) * 10)
            return {1'b0, 8'hFF, 8'hFF};
        nib = m_num[31 - 4*d -: 4];
        seg = (nib == 4'hF) ? 8'hFF : dec_tab[nib];
        seg[7] = ~m_dp[d];
        return {m_t == 0, ~(8'd1 << d), seg};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_on = 1'b0; m_t = 0; m_num = '0; m_dp = '0; m_b = '0;
            exp_q.delete();
        end else begin
            exp_q.push_back(model_out());
            if (!bus.en_in) begin
                m_on = 1'b0; m_t = 0;
            end else if (!m_on) begin
                m_on = 1'b1; m_t = 0;
                m_num = bus.num_in; m_dp = bus.dp_in; m_b = bus.bright_in;
            end else begin
                m_t = (m_t + 1) % 640;
                if (m_t == 0) begin
                    m_num = bus.num_in; m_dp = bus.dp_in; m_b = bus.bright_in;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst)
            chk("reset_dark", observed(), 17'h0FFFF);
        else if (exp_q.size() > 0)
            chk("scoreboard", observed(), exp_q.pop_front());
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic adv(input int n);
        repeat (n) cyc();
    endtask

    task automatic chk_out(input string tag, input logic [7:0] sel,
                           input logic [7:0] seg, input logic fr);
        chk(tag, observed(), {fr, sel, seg});
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.frame_out !== 1'b1 && n < 1500);
        checks++;
        assert (n < 1500) else begin
            errors++;
            $error("FAIL frame_timeout: observed %0d cycles required < 1500", n);
        end
    endtask

    initial begin
        int n;
        dec_tab[0]  = 8'hC0; dec_tab[1]  = 8'hF9; dec_tab[2]  = 8'hA4; dec_tab[3]  = 8'hB0;
        dec_tab[4]  = 8'h99; dec_tab[5]  = 8'h92; dec_tab[6]  = 8'h82; dec_tab[7]  = 8'hF8;
        dec_tab[8]  = 8'h80; dec_tab[9]  = 8'h90; dec_tab[10] = 8'h88; dec_tab[11] = 8'h83;
        dec_tab[12] = 8'hC6; dec_tab[13] = 8'hA1; dec_tab[14] = 8'h86; dec_tab[15] = 8'h8E;

        bus.en_in = 1'b0; bus.num_in = '0; bus.dp_in = '0; bus.bright_in = '0;

        // Reset and idle
        adv(3);
        chk_out("reset_state", 8'hFF, 8'hFF, 1'b0);
        rst = 1'b1;
        adv(2);
        chk_out("off_idle", 8'hFF, 8'hFF, 1'b0);

        // Full brightness scan of 01234567
        bus.num_in = 32'h01234567; bus.dp_in = 8'h00; bus.bright_in = 3'd7; bus.en_in = 1'b1;
        cyc();
        chk_out("en_edge_dark", 8'hFF, 8'hFF, 1'b0);
        cyc();
        chk_out("first_digit0", 8'hFE, 8'hC0, 1'b1);
        adv(79);
        chk_out("digit0_end", 8'hFE, 8'hC0, 1'b0);
        adv(1);
        chk_out("digit1_start", 8'hFD, 8'hF9, 1'b0);
        adv(480);
        chk_out("digit7_start", 8'h7F, 8'hF8, 1'b0);
        adv(79);
        chk_out("digit7_end", 8'h7F, 8'hF8, 1'b0);
        adv(1);
        chk_out("frame_wrap", 8'hFE, 8'hC0, 1'b1);
        wait_frame(n);
        checks++;
        assert (n == 640) else begin
            errors++;
            $error("FAIL frame_period: observed %0d required 640", n);
        end

        // Brightness 1: lit 20 of 80 clocks per slot
        bus.bright_in = 3'd1;
        wait_frame(n);
        chk_out("dim_start", 8'hFE, 8'hC0, 1'b1);
        adv(19);
        chk_out("dim_last_lit", 8'hFE, 8'hC0, 1'b0);
        adv(1);
        chk_out("dim_first_dark", 8'hFF, 8'hFF, 1'b0);
        adv(59);
        chk_out("dim_last_dark", 8'hFF, 8'hFF, 1'b0);
        adv(1);
        chk_out("dim_digit1", 8'hFD, 8'hF9, 1'b0);

        // Blank code and decimal point
        bus.num_in = 32'hFFFF3030; bus.dp_in = 8'h01; bus.bright_in = 3'd7;
        wait_frame(n);
        chk_out("blank_dp_d0", 8'hFE, 8'h7F, 1'b1);
        adv(80);
        chk_out("blank_d1", 8'hFD, 8'hFF, 1'b0);
        adv(80);
        chk_out("blank_d2", 8'hFB, 8'hFF, 1'b0);
        adv(80);
        chk_out("blank_d3", 8'hF7, 8'hFF, 1'b0);
        adv(80);
        chk_out("digit4_3", 8'hEF, 8'hB0, 1'b0);
        adv(80);
        chk_out("digit5_0", 8'hDF, 8'hC0, 1'b0);

        // Mid-frame source change must not tear
        bus.num_in = 32'h11111111; bus.dp_in = 8'h00;
        wait_frame(n);
        adv(240);
        chk_out("tear_d3_before", 8'hF7, 8'hF9, 1'b0);
        bus.num_in = 32'h22222222;
        adv(320);
        chk_out("tear_d7_old", 8'h7F, 8'hF9, 1'b0);
        adv(80);
        chk_out("tear_next_frame", 8'hFE, 8'hA4, 1'b1);

        // Enable drop during digit 5, restart 7 clocks later
        adv(410);
        chk_out("pre_drop_d5", 8'hDF, 8'hA4, 1'b0);
        bus.en_in = 1'b0;
        cyc();
        chk_out("en_drop_dark", 8'hFF, 8'hFF, 1'b0);
        adv(6);
        chk_out("en_off_hold", 8'hFF, 8'hFF, 1'b0);
        bus.en_in = 1'b1;
        cyc();
        chk_out("restart_edge", 8'hFF, 8'hFF, 1'b0);
        cyc();
        chk_out("restart_digit0", 8'hFE, 8'hA4, 1'b1);

        // Asynchronous reset mid-slot
        adv(85);
        chk_out("pre_reset_d1", 8'hFD, 8'hA4, 1'b0);
        #1 rst = 1'b0;
        #1 chk_out("async_reset", 8'hFF, 8'hFF, 1'b0);
        adv(3);
        rst = 1'b1;
        cyc();
        chk_out("post_reset_edge", 8'hFF, 8'hFF, 1'b0);
        cyc();
        chk_out("post_reset_digit0", 8'hFE, 8'hA4, 1'b1);
        adv(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Scan controller for the 8-digit common-anode seven-segment display. It takes the 32-bit packed hex digit word produced by the display datapath (scrolling-number, counter and similar generators) and time-multiplexes it onto the shared segment and digit-select pins. It also handles per-digit decimal points, blank-code suppression and 8-level brightness PWM. The digit word is snapshotted once per frame so that a source updating mid-frame never causes tearing.

## Interface
- FREQUENCY_IN, 50_000_000: input clock frequency in Hz.
- SCAN_HZ, 8_000: digit-slot rate in Hz. One frame is 8 slots. SLOT_CNT = FREQUENCY_IN / SCAN_HZ must be a multiple of 8 and ≥ 16.
- BLANK_EN, 1: when 1, nibble 4'hF is displayed as all segments off instead of "F".
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en_in  in  1  scan enable. When low, the display is dark and the scan is held at its start.
- num_in  in  32  packed digits. Digit 0 (leftmost) is [31:28]; digit 7 is [3:0].
- dp_in  in  8  decimal point enables. dp_in[i] lights the dot of digit i.
- bright_in  in  3  brightness level b. A digit is lit for (b+1)/8 of its slot.
- seg_out  out  8  active-low segments, ordered {dp,g,f,e,d,c,b,a}.
- sel_out  out  8  active-low digit select. sel_out[i] drives digit i; at most one bit is low at any time.
- frame_out  out  1  one-cycle pulse, high during the first output cycle of each frame.

## Operation
- Counters:
  - cnt runs 0..SUB_CNT-1, where SUB_CNT = SLOT_CNT/8.
  - sub (3 bits) advances when cnt wraps.
  - digit (3 bits) advances when sub wraps 7→0, and wraps 7→0 itself.
- States:
  - OFF: en_in low or just out of reset. All counters are held at 0. Outputs are seg_out=8'hFF, sel_out=8'hFF, frame_out=0. OFF→SCAN on en_in=1.
  - SCAN: counters free-run. Any cycle with en_in=0 forces OFF at the next edge, which clears the counters and darkens the outputs.
- Snapshot: num_in, dp_in and bright_in are latched into shadow registers at the edge where the counters enter digit 0, sub 0, cnt 0. This happens on the OFF→SCAN entry and on every 7→0 digit wrap. Input changes at any other time have no effect until the next frame.
- Lit condition: sub ≤ shadow bright. When lit, sel_out has only bit [digit] low and seg_out = decode(nibble) with bit 7 = ~dp[digit]. When not lit, sel_out=8'hFF and seg_out=8'hFF.
- Decode, active-low, with dp bit set:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86
  - F=8E, or FF when BLANK_EN=1. A blanked digit still shows its dp when dp is set (seg_out=7F).
- bright_in=7 gives 100% duty, so no dark gap occurs inside a frame.
- Arithmetic: SUB_CNT is computed at elaboration. cnt width is $clog2(SUB_CNT).

## Timing
- Reset: when rst goes low, seg_out=8'hFF, sel_out=8'hFF and frame_out=0 immediately, asynchronously. State is OFF, all counters are 0 and all shadows are 0.
- Outputs are registered and lag the counter state by exactly 1 clock.
- en_in rising at edge E (state becomes SCAN with counters at 0 and snapshot taken). The first lit digit-0 output and the frame_out pulse appear after edge E+1.
- en_in low sampled at edge E: outputs are dark after edge E+1 at the latest.
- Frame period: exactly 8·SLOT_CNT clocks. frame_out pulses are spaced by that period. Each digit holds its selection for (b+1)·SUB_CNT consecutive clocks per frame.
- Reset or en_in drop mid-frame: the partial frame is abandoned. The next frame restarts at digit 0 with a fresh snapshot. No glitch can select two digits at once.

## Test plan
Bench parameters: FREQUENCY_IN=640, SCAN_HZ=8, giving SLOT_CNT=80 and SUB_CNT=10.
- Reset, then en_in=1, num_in=32'h01234567, dp_in=0, bright_in=7:
  - digit 0 shows sel_out=8'hFE, seg_out=C0 for 80 clocks, then sel_out=8'hFD, seg_out=F9.
  - digit 7 shows 8'h7F/F8.
  - frame_out pulses every 640 clocks.
- bright_in=1: each digit is lit for 20 clocks, then sel_out=seg_out=8'hFF for 60 clocks.
- num_in=32'hFFFF3030, BLANK_EN=1, dp_in=8'h01: digits 0–3 read FF except digit 0, which reads 7F; digit 4 reads B0; digit 5 reads C0.
- Change num_in from 32'h11111111 to 32'h22222222 during digit 3: the current frame shows only F9 on every digit. The next frame shows A4 from digit 0.
- Drop en_in during digit 5, then raise it 7 clocks later:
  - outputs are 8'hFF one clock after the drop.
  - on restart, digit 0 is selected one clock after en_in is sampled high, and frame_out pulses.
- Assert rst mid-slot: outputs are FF/FF/0 asynchronously. After release with en_in=1, the scan restarts at digit 0.
